// File: rtl/cs_pkg.sv
// Shared definitions for the colour-sensor filter sequencer.
//
// Contents:
//   filter_e - S2,S3 filter codes driven to the sensor
//   color_e  - colour result codes reported after a run
//   state_e  - sequencer FSM states
//   default values for the sequencer parameters
//
// Optional feature macro: CS_CLEAR_CHECK_EN.
// Without it, the C_SET/C_MEAS states are never entered.
package cs_pkg;

  typedef enum logic [1:0] {
    RED_FILTER   = 2'd0,
    BLUE_FILTER  = 2'd1,
    CLEAR_FILTER = 2'd2,
    GREEN_FILTER = 2'd3
  } filter_e;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    RED   = 2'd1,
    GREEN = 2'd2,
    BLUE  = 2'd3
  } color_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_R_SET,
    ST_R_MEAS,
    ST_G_SET,
    ST_G_MEAS,
    ST_B_SET,
    ST_B_MEAS,
    ST_C_SET,
    ST_C_MEAS,
    ST_DONE
  } state_e;

  localparam int         DEF_SETTLE_CYCLES = 20;
  localparam int         DEF_WINDOW_CYCLES = 500;
  localparam int         DEF_CNT_W         = 16;
  localparam int         DEF_MIN_COUNT     = 8;
  localparam logic [1:0] DEF_SCALER        = 2'b11;

endpackage

// File: rtl/cs_edge_sync.sv
// Brings the asynchronous sensor output into the clk_1MHz domain and turns
// each rising edge into a single-cycle pulse.
//
// Ports:
//   clk_1MHz - system clock
//   rst_n    - synchronous, active-low reset
//   d        - asynchronous input (sensor OUT pin)
//   pulse    - one-cycle pulse per rising edge of d, 2-3 cycles late
module cs_edge_sync (
  input  logic clk_1MHz,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync3;

  // Two flops resolve metastability; the third remembers the previous
  // synchronised level so a 0->1 change can be spotted.
  always_ff @(posedge clk_1MHz) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= d;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign pulse = r_sync2 & ~r_sync3;

endmodule

// File: rtl/cs_filter_sequencer.sv
// Steps a TCS3200-style colour sensor through its RED, GREEN and BLUE
// filters (plus CLEAR when CS_CLEAR_CHECK_EN is defined). It counts sensor
// edges over a fixed window per filter and then reports the dominant colour.
//
// Ports:
//   clk_1MHz    - system clock, 1 MHz
//   rst_n       - synchronous, active-low reset
//   start       - begin a run; only looked at in IDLE
//   cs_out      - sensor frequency output, asynchronous
//   filter      - S2,S3 filter select
//   cs_scaler   - S0,S1 output scaling, fixed at SCALER
//   busy        - a run is in progress
//   color       - last result (0 none, 1 red, 2 green, 3 blue)
//   color_valid - one-cycle pulse when a new result is presented
//   *_freq      - latched edge count of each phase
//
// Optional feature macro: CS_CLEAR_CHECK_EN adds a CLEAR phase. Its count
// then becomes the "is anything in front of the sensor" test.
module cs_filter_sequencer
  import cs_pkg::*;
#(
  parameter int         SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int         WINDOW_CYCLES = DEF_WINDOW_CYCLES,
  parameter int         CNT_W         = DEF_CNT_W,
  parameter int         MIN_COUNT     = DEF_MIN_COUNT,
  parameter logic [1:0] SCALER        = DEF_SCALER
) (
  input  logic             clk_1MHz,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cs_out,
  output logic [1:0]       filter,
  output logic [1:0]       cs_scaler,
  output logic             busy,
  output logic [1:0]       color,
  output logic             color_valid,
  output logic [CNT_W-1:0] red_freq,
  output logic [CNT_W-1:0] green_freq,
  output logic [CNT_W-1:0] blue_freq,
  output logic [CNT_W-1:0] clear_freq
);

  localparam int CYC_MAX = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);
  localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYCLES - 1);
  localparam logic [CYC_W-1:0] WINDOW_LAST = CYC_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] MIN_CNT     = CNT_W'(MIN_COUNT);

  state_e           r_state;
  state_e           w_nextState;
  filter_e          w_filter;
  logic             w_isMeas;
  logic             w_edge;
  logic [CYC_W-1:0] r_cycleCnt;
  logic [CNT_W-1:0] r_edgeCnt;
  logic [CNT_W-1:0] r_redFreq;
  logic [CNT_W-1:0] r_greenFreq;
  logic [CNT_W-1:0] r_blueFreq;
  color_e           r_color;
  color_e           w_decision;
  logic [CNT_W-1:0] w_winCount;
  logic             w_settleDone;
  logic             w_windowDone;

  cs_edge_sync u_edge_sync (
    .clk_1MHz (clk_1MHz),
    .rst_n    (rst_n),
    .d        (cs_out),
    .pulse    (w_edge)
  );

  assign w_settleDone = (r_cycleCnt == SETTLE_LAST);
  assign w_windowDone = (r_cycleCnt == WINDOW_LAST);

  // State register. Reset drops straight back to IDLE from any phase.
  always_ff @(posedge clk_1MHz) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nextState;
  end

  // Next-state logic plus the outputs that depend on the state alone.
  // Filter goes back to CLEAR whenever no colour phase is running.
  always_comb begin
    w_nextState = r_state;
    w_filter    = CLEAR_FILTER;
    w_isMeas    = 1'b0;
    busy        = 1'b0;
    color_valid = 1'b0;
    case (r_state)
      ST_IDLE:   if (start) w_nextState = ST_R_SET;
      ST_R_SET:  begin busy = 1'b1; w_filter = RED_FILTER;
                   if (w_settleDone) w_nextState = ST_R_MEAS; end
      ST_R_MEAS: begin busy = 1'b1; w_filter = RED_FILTER; w_isMeas = 1'b1;
                   if (w_windowDone) w_nextState = ST_G_SET; end
      ST_G_SET:  begin busy = 1'b1; w_filter = GREEN_FILTER;
                   if (w_settleDone) w_nextState = ST_G_MEAS; end
      ST_G_MEAS: begin busy = 1'b1; w_filter = GREEN_FILTER; w_isMeas = 1'b1;
                   if (w_windowDone) w_nextState = ST_B_SET; end
      ST_B_SET:  begin busy = 1'b1; w_filter = BLUE_FILTER;
                   if (w_settleDone) w_nextState = ST_B_MEAS; end
`ifdef CS_CLEAR_CHECK_EN
      ST_B_MEAS: begin busy = 1'b1; w_filter = BLUE_FILTER; w_isMeas = 1'b1;
                   if (w_windowDone) w_nextState = ST_C_SET; end
      ST_C_SET:  begin busy = 1'b1;
                   if (w_settleDone) w_nextState = ST_C_MEAS; end
      ST_C_MEAS: begin busy = 1'b1; w_isMeas = 1'b1;
                   if (w_windowDone) w_nextState = ST_DONE; end
`else
      ST_B_MEAS: begin busy = 1'b1; w_filter = BLUE_FILTER; w_isMeas = 1'b1;
                   if (w_windowDone) w_nextState = ST_DONE; end
`endif
      ST_DONE:   begin color_valid = 1'b1; w_nextState = ST_IDLE; end
      default:   w_nextState = ST_IDLE;
    endcase
  end

  // One cycle counter is shared by every phase. It restarts at zero on each
  // state change, so each phase length is set by its terminal count alone.
  always_ff @(posedge clk_1MHz) begin
    if (!rst_n)                      r_cycleCnt <= '0;
    else if (w_nextState != r_state) r_cycleCnt <= '0;
    else if (r_state != ST_IDLE)     r_cycleCnt <= r_cycleCnt + 1'b1;
  end

  // A single edge counter serves all phases. It is held at zero outside the
  // measurement windows, so settle-time edges never count. It sticks at
  // all-ones instead of wrapping.
  always_ff @(posedge clk_1MHz) begin
    if (!rst_n)                          r_edgeCnt <= '0;
    else if (!w_isMeas)                  r_edgeCnt <= '0;
    else if (w_edge && r_edgeCnt != '1)  r_edgeCnt <= r_edgeCnt + 1'b1;
  end

  // Capture the count on the last cycle of each window. An edge pulse that
  // lands in that same cycle is dropped.
  always_ff @(posedge clk_1MHz) begin
    if (!rst_n) begin
      r_redFreq   <= '0;
      r_greenFreq <= '0;
      r_blueFreq  <= '0;
    end else if (w_windowDone) begin
      if (r_state == ST_R_MEAS) r_redFreq   <= r_edgeCnt;
      if (r_state == ST_G_MEAS) r_greenFreq <= r_edgeCnt;
      if (r_state == ST_B_MEAS) r_blueFreq  <= r_edgeCnt;
    end
  end

`ifdef CS_CLEAR_CHECK_EN
  logic [CNT_W-1:0] r_clearFreq;

  always_ff @(posedge clk_1MHz) begin
    if (!rst_n)                                      r_clearFreq <= '0;
    else if (w_windowDone && r_state == ST_C_MEAS)   r_clearFreq <= r_edgeCnt;
  end

  assign clear_freq = r_clearFreq;
`else
  assign clear_freq = '0;
`endif

  // Pick the largest of the three counts. The >= comparisons give ties to
  // red first, then green. The no-object test uses either the CLEAR count
  // or the winning count, depending on the build.
  always_comb begin
    w_decision = RED;
    w_winCount = r_redFreq;
    if (r_redFreq >= r_greenFreq && r_redFreq >= r_blueFreq) begin
      w_decision = RED;
      w_winCount = r_redFreq;
    end else if (r_greenFreq >= r_blueFreq) begin
      w_decision = GREEN;
      w_winCount = r_greenFreq;
    end else begin
      w_decision = BLUE;
      w_winCount = r_blueFreq;
    end
`ifdef CS_CLEAR_CHECK_EN
    if (r_clearFreq < MIN_CNT) w_decision = NONE;
`else
    if (w_winCount < MIN_CNT)  w_decision = NONE;
`endif
  end

  // The result appears combinationally during DONE, when blue (or clear) has
  // just been latched. It is held in r_color until the next DONE.
  always_ff @(posedge clk_1MHz) begin
    if (!rst_n)                  r_color <= NONE;
    else if (r_state == ST_DONE) r_color <= w_decision;
  end

  assign color      = (r_state == ST_DONE) ? w_decision : r_color;
  assign filter     = w_filter;
  assign cs_scaler  = SCALER;
  assign red_freq   = r_redFreq;
  assign green_freq = r_greenFreq;
  assign blue_freq  = r_blueFreq;

endmodule

// File: tb/tb_cs_filter_sequencer.sv
// Self-checking bench for cs_filter_sequencer. A small sensor model picks the
// cs_out period from the filter the DUT is currently selecting.
module tb_cs_filter_sequencer;

`ifdef CS_CLEAR_CHECK_EN
  localparam int EXP_LAT = 2081;
`else
  localparam int EXP_LAT = 1561;
`endif

  logic        clk_1MHz = 1'b0;
  logic        rst_n    = 1'b0;
  logic        start    = 1'b0;
  logic        cs_out;
  logic [1:0]  filter;
  logic [1:0]  cs_scaler;
  logic        busy;
  logic [1:0]  color;
  logic        color_valid;
  logic [15:0] red_freq;
  logic [15:0] green_freq;
  logic [15:0] blue_freq;
  logic [15:0] clear_freq;

  int nCompared   = 0;
  int nMismatched = 0;

  int tick = 0;
  int rP = 0;
  int gP = 0;
  int bP = 0;
  int cP = 0;
  int curP;

  typedef struct {
    string name;
    int rP; int gP; int bP; int cP;
    int expR; int expG; int expB; int expC;
    int expColor;
  } vec_t;

  vec_t vecs[5];

  cs_filter_sequencer dut (
    .clk_1MHz    (clk_1MHz),
    .rst_n       (rst_n),
    .start       (start),
    .cs_out      (cs_out),
    .filter      (filter),
    .cs_scaler   (cs_scaler),
    .busy        (busy),
    .color       (color),
    .color_valid (color_valid),
    .red_freq    (red_freq),
    .green_freq  (green_freq),
    .blue_freq   (blue_freq),
    .clear_freq  (clear_freq)
  );

  // 1 MHz clock scaled to 10 time units per period.
  always #5 clk_1MHz = ~clk_1MHz;

  // Free-running cycle count that drives the sensor square wave.
  always @(posedge clk_1MHz) tick <= tick + 1;

  // Sensor model: the square-wave period follows the selected filter, and
  // a period of zero holds the output low.
  always @* begin
    case (filter)
      2'd0:    curP = rP;
      2'd3:    curP = gP;
      2'd1:    curP = bP;
      default: curP = cP;
    endcase
    cs_out = (curP != 0) && ((tick % curP) < (curP / 2));
  end

  task automatic checkOutput(input string name, input int act, input int lo, input int hi);
    nCompared++;
    if (act < lo || act > hi) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic checkNear(input string name, input int act, input int exp);
    if (exp == 0) checkOutput(name, act, 0, 0);
    else          checkOutput(name, act, exp - 2, exp + 2);
  endtask

  // Pulse (or hold) start and wait for color_valid. lat counts the edges
  // from the one that samples start up to the one that raises color_valid.
  task automatic applyStimulus(input vec_t v, input bit holdStart, output int lat);
    rP = v.rP; gP = v.gP; bP = v.bP; cP = v.cP;
    @(posedge clk_1MHz); #1;
    start = 1'b1;
    @(posedge clk_1MHz); #1;
    lat = 1;
    if (!holdStart) start = 1'b0;
    checkOutput({v.name, " busy after start"}, int'(busy), 1, 1);
    while (!color_valid && lat < 6000) begin
      @(posedge clk_1MHz); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int validCnt;

    vecs[0] = '{"rgb_red",  10, 20, 25, 10, 50, 25, 20, 0, 1};
    vecs[1] = '{"rgb_blue", 20, 20,  8, 10, 25, 25, 62, 0, 3};
    vecs[2] = '{"tie",      10, 10, 10, 10, 50, 50, 50, 0, 1};
    vecs[3] = '{"dark",      0,  0,  0,  0,  0,  0,  0, 0, 0};
    vecs[4] = '{"weak_red",100,  0,  0, 10,  5,  0,  0, 0, 0};
`ifdef CS_CLEAR_CHECK_EN
    vecs[0].expC = 50;
    vecs[1].expC = 50;
    vecs[2].expC = 50;
    vecs[4].expC = 50;
    vecs[4].expColor = 1;
`endif

    // Reset state.
    repeat (3) @(posedge clk_1MHz);
    #1;
    checkOutput("reset filter",      int'(filter),      2, 2);
    checkOutput("reset cs_scaler",   int'(cs_scaler),   3, 3);
    checkOutput("reset busy",        int'(busy),        0, 0);
    checkOutput("reset color",       int'(color),       0, 0);
    checkOutput("reset color_valid", int'(color_valid), 0, 0);
    checkOutput("reset red_freq",    int'(red_freq),    0, 0);
    checkOutput("reset clear_freq",  int'(clear_freq),  0, 0);
    rst_n = 1'b1;

    // Reset in the middle of the BLUE window aborts the run silently.
    rP = 10; gP = 20; bP = 25; cP = 10;
    @(posedge clk_1MHz); #1;
    start = 1'b1;
    @(posedge clk_1MHz); #1;
    start = 1'b0;
    repeat (1300) @(posedge clk_1MHz);
    #1;
    checkOutput("pre-abort filter blue", int'(filter), 1, 1);
    checkOutput("pre-abort busy",        int'(busy),   1, 1);
    rst_n = 1'b0;
    @(posedge clk_1MHz); #1;
    rst_n = 1'b1;
    checkOutput("abort filter",      int'(filter),      2, 2);
    checkOutput("abort busy",        int'(busy),        0, 0);
    checkOutput("abort color_valid", int'(color_valid), 0, 0);
    checkOutput("abort red_freq",    int'(red_freq),    0, 0);
    checkOutput("abort green_freq",  int'(green_freq),  0, 0);
    validCnt = 0;
    repeat (EXP_LAT + 100) begin
      @(posedge clk_1MHz); #1;
      if (color_valid) validCnt++;
    end
    checkOutput("abort no result", validCnt, 0, 0);

    // Table-driven runs.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i], 1'b0, lat);
      $display("[TB] vector %s: latency %0d, color %0d", vecs[i].name, lat, color);
      checkOutput({vecs[i].name, " latency"},     lat,              EXP_LAT, EXP_LAT);
      checkOutput({vecs[i].name, " color"},       int'(color),      vecs[i].expColor, vecs[i].expColor);
      checkOutput({vecs[i].name, " busy done"},   int'(busy),       0, 0);
      checkOutput({vecs[i].name, " filter done"}, int'(filter),     2, 2);
      checkNear({vecs[i].name, " red_freq"},   int'(red_freq),   vecs[i].expR);
      checkNear({vecs[i].name, " green_freq"}, int'(green_freq), vecs[i].expG);
      checkNear({vecs[i].name, " blue_freq"},  int'(blue_freq),  vecs[i].expB);
      checkNear({vecs[i].name, " clear_freq"}, int'(clear_freq), vecs[i].expC);
      @(posedge clk_1MHz); #1;
      checkOutput({vecs[i].name, " valid one cycle"}, int'(color_valid), 0, 0);
      checkOutput({vecs[i].name, " color held"},      int'(color),       vecs[i].expColor, vecs[i].expColor);
    end

    // start held high across DONE: one IDLE cycle, then the next run begins.
    applyStimulus(vecs[0], 1'b1, lat);
    checkOutput("held latency", lat,         EXP_LAT, EXP_LAT);
    checkOutput("held color",   int'(color), 1, 1);
    @(posedge clk_1MHz); #1;
    checkOutput("held idle busy",  int'(busy),        0, 0);
    checkOutput("held idle valid", int'(color_valid), 0, 0);
    @(posedge clk_1MHz); #1;
    checkOutput("held rerun busy",   int'(busy),   1, 1);
    checkOutput("held rerun filter", int'(filter), 0, 0);
    start = 1'b0;

    // start pulses during a run are ignored: exactly one result follows.
    repeat (3) begin
      repeat (100) @(posedge clk_1MHz);
      #1;
      start = 1'b1;
      @(posedge clk_1MHz); #1;
      start = 1'b0;
    end
    validCnt = 0;
    repeat (EXP_LAT) begin
      @(posedge clk_1MHz); #1;
      if (color_valid) validCnt++;
    end
    checkOutput("busy start ignored", validCnt,   1, 1);
    checkOutput("final busy",         int'(busy), 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
